// File: rtl/td4_prog_loader.sv
// TD4 program store: a host streams nibbles in over the load port and the CPU
// is held in reset until the program is complete or the host ends the load early.
module td4_prog_loader #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  FILL_WORD = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [3:0] ld_data,
  input  logic       ld_go,
  input  logic [3:0] pc,
  output logic [3:0] opcode,
  output logic [3:0] immediate,
  output logic       cpu_rst_n,
  output logic       loading,
  output logic [3:0] ld_addr,
  output logic       ld_phase
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] ld_addr_q, ld_addr_d;
  logic       ld_phase_q, ld_phase_d;
  logic [3:0] hold_q, hold_d;
  logic       cpu_rst_n_q, cpu_rst_n_d;
  logic       wr_en;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  // Arbitration order inside LOAD: ld_start, then ld_go, then ld_valid.
  always_comb begin
    state_d    = state_q;
    ld_addr_d  = ld_addr_q;
    ld_phase_d = ld_phase_q;
    hold_d     = hold_q;
    wr_en      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (ld_start) begin
          ld_addr_d  = '0;
          ld_phase_d = 1'b0;
        end else if (ld_go) begin
          state_d    = ST_RUN;
          ld_phase_d = 1'b0;
        end else if (ld_valid) begin
          if (!ld_phase_q) begin
            hold_d     = ld_data;
            ld_phase_d = 1'b1;
          end else begin
            wr_en      = 1'b1;
            ld_phase_d = 1'b0;
            ld_addr_d  = ld_addr_q + 4'd1;
            if (ld_addr_q == 4'hF) state_d = ST_RUN;
          end
        end
      end
      default: begin
        if (ld_start) begin
          state_d    = ST_LOAD;
          ld_addr_d  = '0;
          ld_phase_d = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[ld_addr_q] = {hold_q, ld_data};
  end

  // CPU reset release lags RUN entry by one cycle.
  always_comb cpu_rst_n_d = (state_q == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      ld_addr_q   <= '0;
      ld_phase_q  <= 1'b0;
      hold_q      <= '0;
      cpu_rst_n_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= FILL_WORD;
    end else begin
      state_q     <= state_d;
      ld_addr_q   <= ld_addr_d;
      ld_phase_q  <= ld_phase_d;
      hold_q      <= hold_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign opcode    = mem_q[pc][7:4];
  assign immediate = mem_q[pc][3:0];
  assign cpu_rst_n = cpu_rst_n_q;
  assign loading   = (state_q == ST_LOAD);
  assign ld_addr   = ld_addr_q;
  assign ld_phase  = ld_phase_q;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Bench for td4_prog_loader: directed load scenarios plus random traffic against
// a nibble-count reference model of the program store.
`timescale 1ns/1ps
module tb_td4_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_start, ld_valid, ld_go;
  logic [3:0] ld_data, pc;
  logic [3:0] opcode, immediate, ld_addr;
  logic       cpu_rst_n, loading, ld_phase;

  always #5 clk = ~clk;

  td4_prog_loader #(.DEPTH(16), .FILL_WORD(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_go(ld_go), .pc(pc), .opcode(opcode),
    .immediate(immediate), .cpu_rst_n(cpu_rst_n), .loading(loading),
    .ld_addr(ld_addr), .ld_phase(ld_phase)
  );

  // Reference model: progress through a load is a nibble count 0..31.
  logic [7:0] mm [16];
  int         mcount;
  bit         mload, mrun, mcpu;
  logic [3:0] mhold;
  int         ncmp = 0;
  int         nfail = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mm[i] = 8'h00;
    mcount = 0; mload = 0; mrun = 0; mcpu = 0; mhold = 4'h0;
  endtask

  task automatic check_status();
    check("loading", {7'd0, loading}, {7'd0, mload});
    check("cpu_rst_n", {7'd0, cpu_rst_n}, {7'd0, mcpu});
    if (mload) begin
      check("ld_addr", {4'd0, ld_addr}, 8'(mcount / 2));
      check("ld_phase", {7'd0, ld_phase}, 8'(mcount % 2));
    end
  endtask

  task automatic cyc(input bit s, input bit v, input logic [3:0] d, input bit g);
    ld_start = s; ld_valid = v; ld_data = d; ld_go = g;
    @(posedge clk);
    mcpu = mrun;
    if (s) begin
      mload = 1; mrun = 0; mcount = 0;
    end else if (mload) begin
      if (g) begin
        mload = 0; mrun = 1; mcount = mcount - (mcount % 2);
      end else if (v) begin
        if (mcount % 2 == 0) mhold = d;
        else mm[mcount / 2] = {mhold, d};
        mcount++;
        if (mcount == 32) begin
          mload = 0; mrun = 1; mcount = 0;
        end
      end
    end
    #1;
    ld_start = 0; ld_valid = 0; ld_go = 0;
    check_status();
  endtask

  task automatic sweep(input string tag);
    for (int p = 0; p < 16; p++) begin
      pc = 4'(p);
      #0.2;
      check({tag, "_op"}, {4'd0, opcode}, {4'd0, mm[p][7:4]});
      check({tag, "_imm"}, {4'd0, immediate}, {4'd0, mm[p][3:0]});
    end
  endtask

  task automatic read_word(input string tag, input logic [3:0] p, input logic [7:0] exp);
    pc = p;
    #0.2;
    check(tag, {opcode, immediate}, exp);
  endtask

  initial begin
    logic [3:0] nib;
    rst_n = 1'b0; ld_start = 0; ld_valid = 0; ld_data = 0; ld_go = 0; pc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: reset state
    check("rst_cpu", {7'd0, cpu_rst_n}, 8'd0);
    check("rst_loading", {7'd0, loading}, 8'd0);
    check("rst_addr", {4'd0, ld_addr}, 8'd0);
    check("rst_phase", {7'd0, ld_phase}, 8'd0);
    sweep("t1");

    // 2: back-to-back full load, word i = {i, ~i}
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      nib = 4'(i);
      cyc(0, 1, nib, 0);
      cyc(0, 1, ~nib, 0);
    end
    check("t2_loading_drop", {7'd0, loading}, 8'd0);
    check("t2_cpu_still_low", {7'd0, cpu_rst_n}, 8'd0);
    cyc(0, 0, 0, 0);
    check("t2_cpu_high", {7'd0, cpu_rst_n}, 8'd1);
    read_word("t2_pc5", 4'd5, 8'h5A);
    sweep("t2");

    // 3: same load with 3 idle cycles between nibbles
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      nib = 4'(i);
      cyc(0, 1, nib, 0);
      repeat (3) cyc(0, 0, 4'hF, 0);
      cyc(0, 1, ~nib, 0);
      if (i < 15) repeat (3) cyc(0, 0, 4'hF, 0);
    end
    cyc(0, 0, 0, 0);
    sweep("t3");

    // 4: partial load of three words then ld_go
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 4'hC, 0);
      cyc(0, 1, 4'h7, 0);
    end
    cyc(0, 1, 4'h9, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("t4_cpu", {7'd0, cpu_rst_n}, 8'd1);
    read_word("t4_pc1", 4'd1, 8'hC7);
    read_word("t4_pc3", 4'd3, 8'h3C);
    sweep("t4");

    // 5: ld_start in RUN together with ld_valid
    cyc(1, 1, 4'h5, 0);
    check("t5_loading", {7'd0, loading}, 8'd1);
    check("t5_addr", {4'd0, ld_addr}, 8'd0);
    check("t5_phase", {7'd0, ld_phase}, 8'd0);
    cyc(0, 0, 0, 0);
    check("t5_cpu_low", {7'd0, cpu_rst_n}, 8'd0);

    // 6: async reset mid-load at ld_addr=7, ld_phase=1
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 4'($urandom), 0);
      cyc(0, 1, 4'($urandom), 0);
    end
    cyc(0, 1, 4'hE, 0);
    check("t6_addr_pre", {4'd0, ld_addr}, 8'd7);
    check("t6_phase_pre", {7'd0, ld_phase}, 8'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_loading", {7'd0, loading}, 8'd0);
    check("t6_cpu", {7'd0, cpu_rst_n}, 8'd0);
    check("t6_addr", {4'd0, ld_addr}, 8'd0);
    check("t6_phase", {7'd0, ld_phase}, 8'd0);
    sweep("t6");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_status();

    // 7: random traffic with gaps, early go and restarts
    for (int r = 0; r < 8; r++) begin
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 90; k++) begin
        cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
            4'($urandom), ($urandom_range(0, 99) < 2));
      end
      cyc(0, 0, 0, 0);
      sweep("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
